// File: rtl/qpu_exu_wbck_arb_if.sv
// Writeback request bundle for the ALU and long-pipe requesters of qpu_exu_wbck_arb.
// The master side is the requester pair; the slave side is the arbiter.
interface qpu_exu_wbck_arb_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 6
);
    logic               alu_wbck_i_valid;
    logic               alu_wbck_i_ready;
    logic [RFIDX_W-1:0] alu_wbck_i_idx;
    logic [XLEN-1:0]    alu_wbck_i_data;

    logic               lpipe_wbck_i_valid;
    logic               lpipe_wbck_i_ready;
    logic [RFIDX_W-1:0] lpipe_wbck_i_idx;
    logic [XLEN-1:0]    lpipe_wbck_i_data;

    modport master (
        output alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_data,
        output lpipe_wbck_i_valid, lpipe_wbck_i_idx, lpipe_wbck_i_data,
        input  alu_wbck_i_ready, lpipe_wbck_i_ready
    );

    modport slave (
        input  alu_wbck_i_valid, alu_wbck_i_idx, alu_wbck_i_data,
        input  lpipe_wbck_i_valid, lpipe_wbck_i_idx, lpipe_wbck_i_data,
        output alu_wbck_i_ready, lpipe_wbck_i_ready
    );
endinterface

// File: rtl/qpu_exu_wbck_arb.sv
// Register-file write-port arbiter: routes ALU / long-pipe writebacks to the classical or
// quantum bank by index MSB, one registered cycle later. QPU_WBCK_RR_EN selects round-robin.
module qpu_exu_wbck_arb #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    qpu_exu_wbck_arb_if.slave  wbck,
    input  logic               wbck_stall,
    output logic               cwbck_dest_wen,
    output logic [RFIDX_W-1:0] cwbck_dest_idx,
    output logic [XLEN-1:0]    cwbck_dest_data,
    output logic               qcwbck_dest_wen,
    output logic [RFIDX_W-1:0] qcwbck_dest_idx,
    output logic [XLEN-1:0]    qcwbck_dest_data,
    output logic [15:0]        wbck_conflict_cnt
);
    localparam int BANK = RFIDX_W - 1;

    logic alu_bank, lp_bank, contested, alu_wins;
    logic alu_acc, lp_acc, contest_grant;

    logic               c_wen_q, c_wen_d, q_wen_q, q_wen_d;
    logic [RFIDX_W-1:0] c_idx_q, c_idx_d, q_idx_q, q_idx_d;
    logic [XLEN-1:0]    c_data_q, c_data_d, q_data_q, q_data_d;
    logic [15:0]        cnt_q, cnt_d;

    assign alu_bank  = wbck.alu_wbck_i_idx[BANK];
    assign lp_bank   = wbck.lpipe_wbck_i_idx[BANK];
    assign contested = wbck.alu_wbck_i_valid & wbck.lpipe_wbck_i_valid & (alu_bank == lp_bank);
    // A contested cycle only counts (and moves the pointer) when a grant is actually made.
    assign contest_grant = contested & ~wbck_stall;

`ifdef QPU_WBCK_RR_EN
    logic rr_ptr_q, rr_ptr_d;

    assign alu_wins = ~rr_ptr_q;
    assign rr_ptr_d = rr_ptr_q ^ contest_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    // Long-pipe returns cannot be back-pressured, so they always win a same-bank clash.
    assign alu_wins = 1'b0;
`endif

    assign wbck.alu_wbck_i_ready   = ~wbck_stall & (~contested | alu_wins);
    assign wbck.lpipe_wbck_i_ready = ~wbck_stall & (~contested | ~alu_wins);

    assign alu_acc = wbck.alu_wbck_i_valid   & wbck.alu_wbck_i_ready;
    assign lp_acc  = wbck.lpipe_wbck_i_valid & wbck.lpipe_wbck_i_ready;

    // At most one accepted write per bank per cycle, so the two branches never collide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        c_wen_d  = 1'b0;
        c_idx_d  = c_idx_q;
        c_data_d = c_data_q;
        q_wen_d  = 1'b0;
        q_idx_d  = q_idx_q;
        q_data_d = q_data_q;
        if (alu_acc) begin
            if (!alu_bank) begin
                c_wen_d  = |wbck.alu_wbck_i_idx[BANK-1:0];
                c_idx_d  = wbck.alu_wbck_i_idx;
                c_data_d = wbck.alu_wbck_i_data;
            end else begin
                q_wen_d  = 1'b1;
                q_idx_d  = wbck.alu_wbck_i_idx;
                q_data_d = wbck.alu_wbck_i_data;
            end
        end
        if (lp_acc) begin
            if (!lp_bank) begin
                c_wen_d  = |wbck.lpipe_wbck_i_idx[BANK-1:0];
                c_idx_d  = wbck.lpipe_wbck_i_idx;
                c_data_d = wbck.lpipe_wbck_i_data;
            end else begin
                q_wen_d  = 1'b1;
                q_idx_d  = wbck.lpipe_wbck_i_idx;
                q_data_d = wbck.lpipe_wbck_i_data;
            end
        end
    end

    assign cnt_d = (contest_grant && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_wen_q  <= 1'b0;
            c_idx_q  <= '0;
            c_data_q <= '0;
            q_wen_q  <= 1'b0;
            q_idx_q  <= '0;
            q_data_q <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            c_wen_q  <= c_wen_d;
            c_idx_q  <= c_idx_d;
            c_data_q <= c_data_d;
            q_wen_q  <= q_wen_d;
            q_idx_q  <= q_idx_d;
            q_data_q <= q_data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cwbck_dest_wen    = c_wen_q;
    assign cwbck_dest_idx    = c_idx_q;
    assign cwbck_dest_data   = c_data_q;
    assign qcwbck_dest_wen   = q_wen_q;
    assign qcwbck_dest_idx   = q_idx_q;
    assign qcwbck_dest_data  = q_data_q;
    assign wbck_conflict_cnt = cnt_q;
endmodule
